// File: rtl/flick_conditioner.sv
// Push-button front-end: synchronise, debounce both edges, stretch each press to HOLD_CYC cycles.
// btn_db/press_pulse follow btn_raw by SYNC_STG+DB_CYC edges; flick follows one edge later.
module flick_conditioner #(
  parameter int SYNC_STG = 2,
  parameter int DB_CYC   = 4,
  parameter int HOLD_CYC = 32,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_raw,
  output logic             flick,
  output logic             btn_db,
  output logic             press_pulse,
  output logic [CNT_W-1:0] glitch_cnt
);

  typedef enum logic [1:0] {IDLE, STRETCH, WAIT_REL} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]    db_cnt_q, db_cnt_d;
  logic                btn_db_q, btn_db_d;
  logic                press_pulse_q, press_pulse_d;
  logic [CNT_W-1:0]    glitch_cnt_q, glitch_cnt_d;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                flick_q, flick_d;
  logic                btn_s;

  assign btn_s = sync_q[SYNC_STG-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], btn_raw};
  end

  // A disagreement run that ends before reaching DB_CYC counts as one rejected glitch.
  always_comb begin
    db_cnt_d      = db_cnt_q;
    btn_db_d      = btn_db_q;
    glitch_cnt_d  = glitch_cnt_q;
    press_pulse_d = 1'b0;
    if (btn_s == btn_db_q) begin
      db_cnt_d = '0;
      if ((db_cnt_q != '0) && (glitch_cnt_q != '1)) begin
        glitch_cnt_d = glitch_cnt_q + ONE;
      end
    end else if (db_cnt_q == DB_LAST) begin
      btn_db_d      = btn_s;
      db_cnt_d      = '0;
      press_pulse_d = btn_s;
    end else begin
      db_cnt_d = db_cnt_q + ONE;
    end
  end

  // press_pulse is tested first everywhere so a new press always wins over hold expiry.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (press_pulse_q) begin
          state_d    = STRETCH;
          hold_cnt_d = HOLD_LD;
        end
      end
      STRETCH: begin
        if (press_pulse_q) begin
          hold_cnt_d = HOLD_LD;
        end else if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - ONE;
        end else if (btn_db_q) begin
          state_d = WAIT_REL;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_REL: begin
        if (press_pulse_q) begin
          state_d    = STRETCH;
          hold_cnt_d = HOLD_LD;
        end else if (!btn_db_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    flick_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      press_pulse_q <= 1'b0;
      glitch_cnt_q  <= '0;
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      flick_q       <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      press_pulse_q <= press_pulse_d;
      glitch_cnt_q  <= glitch_cnt_d;
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      flick_q       <= flick_d;
    end
  end

  assign flick       = flick_q;
  assign btn_db      = btn_db_q;
  assign press_pulse = press_pulse_q;
  assign glitch_cnt  = glitch_cnt_q;

endmodule

// File: tb/tb_flick_conditioner.sv
// Bench for flick_conditioner: history-based reference model checked every cycle plus directed literal checks.
module tb_flick_conditioner;
  localparam int SYNC_STG = 2;
  localparam int DB_CYC   = 4;
  localparam int HOLD_CYC = 8;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn_raw = 1'b0;
  logic             flick, btn_db, press_pulse;
  logic [CNT_W-1:0] glitch_cnt;

  flick_conditioner #(
    .SYNC_STG(SYNC_STG), .DB_CYC(DB_CYC), .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .flick(flick),
    .btn_db(btn_db), .press_pulse(press_pulse), .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: btn_db flips once the last DB_CYC synchronised samples all disagree with it;
  // flick is high within HOLD_CYC edges of a press, or stays high while the button remains down.
  logic sync_m [SYNC_STG] = '{default: 1'b0};
  logic hist_m [DB_CYC]   = '{default: 1'b0};
  logic db_m = 1'b0, pulse_m = 1'b0, flick_m = 1'b0;
  int   glitch_m = 0;
  int   ec_m = 0;
  int   last_p = -1000;
  logic bs, all_diff, flick_n;
  int   since;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STG; i++) sync_m[i] = 1'b0;
      for (int i = 0; i < DB_CYC; i++) hist_m[i] = 1'b0;
      db_m = 1'b0; pulse_m = 1'b0; flick_m = 1'b0; glitch_m = 0;
      last_p = ec_m - 1000;
    end else begin
      ec_m++;
      since   = ec_m - last_p;
      flick_n = ((since >= 1) && (since <= HOLD_CYC)) || (flick_m && db_m);
      bs = sync_m[SYNC_STG-1];
      if ((bs == db_m) && (hist_m[0] != db_m) && (glitch_m < 255)) glitch_m++;
      for (int i = DB_CYC - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
      hist_m[0] = bs;
      all_diff = 1'b1;
      for (int i = 0; i < DB_CYC; i++) if (hist_m[i] == db_m) all_diff = 1'b0;
      pulse_m = 1'b0;
      if (all_diff) begin
        db_m    = bs;
        pulse_m = bs;
        if (bs) last_p = ec_m;
      end
      flick_m = flick_n;
      for (int i = SYNC_STG - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
      sync_m[0] = btn_raw;
    end
  end

  always @(negedge clk) begin
    chk("model_flick", int'(flick), int'(flick_m));
    chk("model_btn_db", int'(btn_db), int'(db_m));
    chk("model_press_pulse", int'(press_pulse), int'(pulse_m));
    chk("model_glitch_cnt", int'(glitch_cnt), glitch_m);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  int   widths [3] = '{1, 2, 3};
  logic seen_hi;

  initial begin
    tick(2);
    do_reset();

    // Clean tap: high for edges 1..5
    btn_raw = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick(1);
      if (e == 5) btn_raw = 1'b0;
      chk("tap_pulse", int'(press_pulse), int'(e == 6));
      chk("tap_btn_db", int'(btn_db), int'(e >= 6 && e <= 10));
      chk("tap_flick", int'(flick), int'(e >= 7 && e <= 14));
    end

    // Long hold: high for edges 1..40
    do_reset();
    btn_raw = 1'b1;
    for (int e = 1; e <= 48; e++) begin
      tick(1);
      if (e == 40) btn_raw = 1'b0;
      chk("hold_btn_db", int'(btn_db), int'(e >= 6 && e <= 45));
      chk("hold_flick", int'(flick), int'(e >= 7 && e <= 46));
    end

    // Short glitches of 1, 2, 3 cycles
    do_reset();
    seen_hi = 1'b0;
    for (int g = 0; g < 3; g++) begin
      btn_raw = 1'b1;
      for (int k = 0; k < widths[g]; k++) begin
        tick(1);
        seen_hi = seen_hi | btn_db | flick;
      end
      btn_raw = 1'b0;
      for (int k = 0; k < 6; k++) begin
        tick(1);
        seen_hi = seen_hi | btn_db | flick;
      end
    end
    chk("glitch_no_output", int'(seen_hi), 0);
    chk("glitch_cnt_3", int'(glitch_cnt), 3);

    for (int i = 0; i < 300; i++) begin
      btn_raw = 1'b1;
      tick(1);
      btn_raw = 1'b0;
      tick(2);
    end
    tick(4);
    chk("glitch_cnt_sat", int'(glitch_cnt), 255);

    // Retrigger: second press_pulse coincides with hold expiry
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      btn_raw = (e <= 4) || (e >= 9 && e <= 12);
      tick(1);
      chk("retrig_pulse", int'(press_pulse), int'(e == 6 || e == 14));
      chk("retrig_btn_db", int'(btn_db), int'((e >= 6 && e <= 9) || (e >= 14 && e <= 17)));
      chk("retrig_flick", int'(flick), int'(e >= 7 && e <= 22));
    end

    // Bounce on press: 1,0,1,0 then held
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      btn_raw = (e == 1) || (e == 3) || (e >= 5);
      tick(1);
      chk("bounce_pulse", int'(press_pulse), int'(e == 10));
      chk("bounce_btn_db", int'(btn_db), int'(e >= 10));
      chk("bounce_flick", int'(flick), int'(e >= 11));
    end
    chk("bounce_glitch_cnt", int'(glitch_cnt), 2);

    // Asynchronous reset mid-press with the button still held
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_flick", int'(flick), 0);
    chk("rst_btn_db", int'(btn_db), 0);
    chk("rst_press_pulse", int'(press_pulse), 0);
    chk("rst_glitch_cnt", int'(glitch_cnt), 0);
    tick(2);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      chk("rst_rel_btn_db", int'(btn_db), int'(e >= 6));
      chk("rst_rel_pulse", int'(press_pulse), int'(e == 6));
      chk("rst_rel_flick", int'(flick), int'(e >= 7));
    end

    btn_raw = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flick_conditioner.md
Name: flick_conditioner

Overview:
- Upstream front-end for bound_flasher: turns a raw, asynchronous, bouncing push-button into the clean `flick` level that the flasher consumes.
- Synchronises the button, debounces it in both directions, then stretches each accepted press to a minimum width. The flasher only samples `flick` at its turning points, so a short tap is still seen.
- Also reports the debounced level, a press pulse, and a count of rejected glitches for debug and verification.

Parameters:
- SYNC_STG, 2: number of synchroniser flops on btn_raw; must be >= 2.
- DB_CYC, 4: consecutive stable cycles required before the debounced level changes; must be >= 1.
- HOLD_CYC, 32: minimum number of cycles `flick` stays high per accepted press; range 1..2^CNT_W.
- CNT_W, 8: width of the debounce counter, the hold counter and glitch_cnt.

Ports:
- clk  input  1  single system clock; all flops are rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_raw  input  1  raw button level; asynchronous to clk and may bounce.
- flick  output  1  stretched, debounced press level; drives bound_flasher.flick.
- btn_db  output  1  debounced button level.
- press_pulse  output  1  one-cycle pulse in the cycle btn_db rises.
- glitch_cnt  output  CNT_W  saturating count of rejected glitches.

Behaviour:
- Reset: rst_n = 0 asynchronously clears every flop.
  - Outputs go to flick = 0, btn_db = 0, press_pulse = 0, glitch_cnt = 0.
  - FSM goes to IDLE; all counters go to 0.
  - Reset mid-press aborts the stretch immediately. After release, a still-held button is treated as a fresh press and needs the full sync and debounce time.
- Synchroniser: btn_s is btn_raw delayed through SYNC_STG flops. There is no logic between the synchroniser flops.
- Debounce, evaluated every edge on btn_s versus btn_db:
  - If btn_s == btn_db: db_cnt <= 0. If db_cnt != 0 at that point, a glitch has been rejected and glitch_cnt increments, saturating at all-ones.
  - If btn_s != btn_db and db_cnt < DB_CYC-1: db_cnt increments.
  - If btn_s != btn_db and db_cnt == DB_CYC-1: btn_db <= btn_s and db_cnt <= 0.
  - Net effect: btn_db changes only after btn_s has differed from it on DB_CYC consecutive edges.
  - press_pulse is registered and is 1 exactly in the cycle where btn_db goes 0 -> 1.
  - The same rule applies to falling edges; a fall produces no pulse.
- Stretch FSM; flick is registered and equals (state != IDLE):
  - IDLE: on press_pulse, go to STRETCH and load hold_cnt = HOLD_CYC-1.
  - STRETCH:
    - If press_pulse occurs (release then re-press), reload hold_cnt = HOLD_CYC-1 and stay (retrigger).
    - Otherwise, if hold_cnt != 0, decrement.
    - Otherwise (hold_cnt == 0), go to WAIT_REL if btn_db = 1, else go to IDLE.
  - WAIT_REL: on btn_db = 0 go to IDLE; on press_pulse go to STRETCH with reload.
- Latency from btn_raw first sampled high (edge 1), with a stable button:
  - btn_db and press_pulse are high after edge SYNC_STG + DB_CYC.
  - flick is high after edge SYNC_STG + DB_CYC + 1.
- Pulse width:
  - Tap shorter than the stretch: flick is high for exactly HOLD_CYC cycles.
  - Long hold: flick falls on the edge after btn_db falls.
  - btn_db falls SYNC_STG + DB_CYC edges after btn_raw falls.
- Simultaneous events: press_pulse has priority over hold_cnt expiry, so the stretch is retriggered rather than ended.
- Glitch rejection: a pulse on btn_s shorter than DB_CYC cycles never changes btn_db and never asserts flick.

Test Plan:
All scenarios use SYNC_STG = 2, DB_CYC = 4, HOLD_CYC = 8, CNT_W = 8.
1. Reset:
   - Stimulus: assert rst_n = 0 mid-cycle with btn_raw = 1.
   - Response: flick, btn_db, press_pulse and glitch_cnt are 0 immediately, without waiting for a clock edge.
   - After release with the button held: btn_db rises at edge 6 and flick at edge 7.
2. Clean tap:
   - Stimulus: btn_raw high for 5 cycles, then low.
   - Response: press_pulse high one cycle at edge 6; flick high from edge 7 for exactly 8 cycles.
   - btn_db falls 6 edges after btn_raw falls.
3. Long hold:
   - Stimulus: btn_raw high for 40 cycles.
   - Response: flick stays high through STRETCH and WAIT_REL; it falls 1 edge after btn_db falls, 7 edges after btn_raw falls.
4. Glitches:
   - Stimulus: three btn_raw pulses of 1, 2 and 3 cycles, separated by 6 low cycles.
   - Response: btn_db and flick stay 0; glitch_cnt = 3.
   - Extra check: drive 300 short glitches and confirm glitch_cnt saturates at 255.
5. Retrigger:
   - Stimulus: tap; release debounces while still in STRETCH; tap again.
   - Response: the second press_pulse reloads the hold counter; flick stays continuously high and ends 8 cycles after the second flick-side pulse.
6. Bounce on press:
   - Stimulus: btn_raw toggles 1,0,1,0, then holds 1.
   - Response: a single press_pulse; flick rises 7 edges after the final rising sample; glitch_cnt increments once per aborted debounce run.
